// File: rtl/counter_checker.sv
// Sequence checker for a free-running modulo-2^WIDTH counter: acquires lock after
// LOCK_N correct increments, then flags broken increments and counts errors and wraps.
module counter_checker #(
  parameter int unsigned WIDTH  = 2,
  parameter int unsigned LOCK_N = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] q,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] wrap_count,
  output logic [WIDTH-1:0] expected
);

  localparam int unsigned RUN_W = (LOCK_N < 1) ? 1 : $clog2(LOCK_N + 1);

  localparam logic [0:0] ACQ    = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [0:0]       state, state_nxt;
  logic [WIDTH-1:0] prev_q, prev_q_nxt;
  logic             have_prev, have_prev_nxt;
  logic [RUN_W-1:0] run, run_nxt;
  logic             locked_nxt, err_nxt;
  logic [CNT_W-1:0] err_count_nxt, wrap_count_nxt;
  logic [WIDTH-1:0] expected_nxt;
  logic             inc_ok;
  logic [RUN_W-1:0] run_inc;

  assign inc_ok  = (q == WIDTH'(prev_q + WIDTH'(1'b1)));
  assign run_inc = RUN_W'(run + RUN_W'(1'b1));

  // State and output registers; reset dominates everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ACQ;
      prev_q     <= '0;
      have_prev  <= 1'b0;
      run        <= '0;
      locked     <= 1'b0;
      err        <= 1'b0;
      err_count  <= '0;
      wrap_count <= '0;
      expected   <= '0;
    end else begin
      state      <= state_nxt;
      prev_q     <= prev_q_nxt;
      have_prev  <= have_prev_nxt;
      run        <= run_nxt;
      locked     <= locked_nxt;
      err        <= err_nxt;
      err_count  <= err_count_nxt;
      wrap_count <= wrap_count_nxt;
      expected   <= expected_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt      = state;
    prev_q_nxt     = q;
    have_prev_nxt  = 1'b1;
    run_nxt        = run;
    err_nxt        = 1'b0;
    err_count_nxt  = err_count;
    wrap_count_nxt = wrap_count;
    expected_nxt   = WIDTH'(q + WIDTH'(1'b1));

    case (state)
      ACQ: begin
        if (have_prev) begin
          if (inc_ok) begin
            if (run_inc == RUN_W'(LOCK_N)) begin
              state_nxt = LOCKED;
              run_nxt   = '0;
            end else begin
              run_nxt = run_inc;
            end
          end else begin
            run_nxt = '0;
          end
        end
      end
      LOCKED: begin
        if (inc_ok) begin
          if (prev_q == '1 && wrap_count != '1)
            wrap_count_nxt = CNT_W'(wrap_count + CNT_W'(1'b1));
        end else begin
          // The bad sample is kept in prev_q so reacquisition starts from it.
          err_nxt   = 1'b1;
          state_nxt = ACQ;
          run_nxt   = '0;
          if (err_count != '1)
            err_count_nxt = CNT_W'(err_count + CNT_W'(1'b1));
        end
      end
      default: begin
        state_nxt = ACQ;
        run_nxt   = '0;
      end
    endcase

    locked_nxt = (state_nxt == LOCKED);
  end

endmodule

// File: doc/counter_checker.md
# counter_checker

Sequence checker sitting on the read side of the free-running `counter` output `q`. It samples `q` every clock and acquires lock after a run of correct modulo-2^WIDTH increments. Once locked, it flags every broken increment, counts errors and wrap-arounds, and exposes the next expected value. It is used as an in-design monitor and as the self-checking element in counter benches, replacing manual `$display` inspection.

## Interface
- `WIDTH`, default 2: width of the observed count.
- `LOCK_N`, default 4: consecutive correct increments required to lock (≥1).
- `CNT_W`, default 8: width of the error and wrap counters.

Ports:
- `clk` input 1: single clock; all logic on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `q` input WIDTH: observed counter value, sampled on every rising edge.
- `locked` output 1: high while the checker is in LOCKED.
- `err` output 1: one-cycle pulse on a mismatch while locked.
- `err_count` output CNT_W: number of mismatches; saturates at all-ones.
- `wrap_count` output CNT_W: number of max→0 wraps seen while locked; saturates at all-ones.
- `expected` output WIDTH: (last sample + 1) mod 2^WIDTH; meaningful when `locked`.

## Operation
- Internal state:
  - `prev_q` (WIDTH bits): last sample.
  - `have_prev` (1 bit): `prev_q` holds a valid sample.
  - `run`: correct-increment counter, range 0..LOCK_N.
  - FSM with two states, ACQ and LOCKED.
- Increment test: `q == prev_q + 1` in WIDTH-bit arithmetic. The carry is dropped, so max→0 is a correct increment.
- Every non-reset edge: `prev_q ← q`, `have_prev ← 1`, `expected ← q + 1` (mod 2^WIDTH).
- ACQ:
  - If `have_prev` = 0, capture only; `run` stays 0.
  - Correct increment: `run ← run + 1`. If `run + 1 == LOCK_N`, go to LOCKED, set `locked ← 1`, and clear `run`.
  - Incorrect increment: `run ← 0`.
  - Never asserts `err`. Never counts wraps, including a wrap on the locking edge.
- LOCKED:
  - Correct increment: stay in LOCKED. If `prev_q` is all-ones (so `q == 0`), `wrap_count` increments, saturating.
  - Incorrect increment: `err ← 1` for exactly one cycle, `err_count` increments (saturating), go to ACQ, `locked ← 0`, `run ← 0`.
  - The bad sample becomes `prev_q`, so reacquisition counts increments starting from it.
- Reset (synchronous, dominates all other events):
  - State ← ACQ.
  - `prev_q`, `have_prev`, `run`, `locked`, `err`, `err_count`, `wrap_count`, `expected` ← 0.
  - `q` is ignored during reset.
- Saturation: at all-ones, `err_count` and `wrap_count` hold their value. `err` still pulses on further mismatches.

## Timing
- All outputs are registered; no combinational path from `q` to any output.
- Sample presented before edge k is judged at edge k. `err`, `locked`, and the counters reflect it from edge k until edge k+1.
- Lock latency from reset release with a clean count: 1 capture edge plus LOCK_N increment edges. For LOCK_N=4, `locked` rises after the 5th sampled edge.
- Unlock latency: the edge at which the bad sample is taken.
- `err` width: exactly 1 cycle per mismatch. A permanently stuck `q` gives one pulse, then the checker stays in ACQ with `err` low.
- Reset asserted mid-lock: all outputs read 0 in the cycle after the reset edge.

## Test plan
All scenarios use WIDTH=2, LOCK_N=4, CNT_W=8 unless stated.

- Reset hold: `reset`=1 for 3 cycles with `q`=2 → `locked`=0, `err`=0, `err_count`=0, `wrap_count`=0, `expected`=0 throughout.
- Clean count: after reset release, `q`=0,1,2,3,0,1,… for 20 samples →
  - `locked` rises after the 5th sample;
  - `err` never asserts;
  - `wrap_count`=3 after the 20th sample (wraps at samples 9, 13, 17; the wrap at the locking sample is not counted);
  - `expected` = `q`+1 mod 4 every cycle.
- Skip injection: while locked, present 0 then 3 instead of 1 → `err` high for 1 cycle and `err_count`=1. Continue 0,1,2,3 → `locked` re-rises on the sample 3.
- Stuck input: while locked, hold `q`=2 for 10 cycles → exactly one `err` pulse, `err_count`=1, `locked` stays 0.
- Saturation: CNT_W=2. Lock, inject a mismatch, reacquire, and repeat 5 times → `err` pulses 5 times, `err_count` reads 1, 2, 3, 3, 3.
- Mid-run reset: locked with `err_count`=1 and `wrap_count`=2, then assert `reset` for 1 cycle → all outputs 0 next cycle. The clean count then relocks after 5 samples with `err_count`=0.
